vram_port_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM (VRAM) between two requesters.
  - The VGA pixel fetch path (display read) has absolute priority.
  - The game-logic sprite/note writer is buffered through a small write queue.
- Sits between the hs/vs/rgb display pipeline and the VRAM.
- Writes posted during active video are held, then drained in cycles where the display does not fetch (h/v blanking).
- Guarantees every pixel fetch is served with fixed latency.

---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_port_arbiter_if.sv | 42 ++++
 rtl/vram_wr_fifo.sv | 73 +++++++
 rtl/vram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM constants, pixel type and arbiter state encoding.
package vram_pkg;

  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 12;
  localparam int DEF_WQ_DEPTH = 4;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bundle of display fetch, writer handshake, VRAM and statistics signals.
interface vram_port_arbiter_if #(
  parameter int ADDR_W   = vram_pkg::DEF_ADDR_W,
  parameter int DATA_W   = vram_pkg::DEF_DATA_W,
  parameter int WQ_DEPTH = vram_pkg::DEF_WQ_DEPTH
);
  localparam int CW = $clog2(WQ_DEPTH) + 1;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CW-1:0]     wq_count;
  logic [15:0]       wr_stall_max;

  // Arbiter side
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr,
           mem_wdata, wq_count, wr_stall_max
  );

  // Display pipeline, writer and VRAM side
  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr,
           mem_wdata, wq_count, wr_stall_max
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Circular write queue; with VRAM_RAW_FWD_EN it also exposes every entry in age order.
module vram_wr_fifo #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [ADDR_W-1:0]           push_addr,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [ADDR_W-1:0]           head_addr,
  output logic [DATA_W-1:0]           head_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
`ifdef VRAM_RAW_FWD_EN
  ,
  output logic [DEPTH-1:0][ADDR_W-1:0] age_addr,
  output logic [DEPTH-1:0][DATA_W-1:0] age_data,
  output logic [DEPTH-1:0]             age_valid
`endif
);
  import vram_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

`ifdef VRAM_RAW_FWD_EN
  // Index 0 is the oldest entry, DEPTH-1 the newest possible
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign age_addr[i]  = addr_mem[rd_ptr + PW'(i)];
    assign age_data[i]  = data_mem[rd_ptr + PW'(i)];
    assign age_valid[i] = (CW'(i) < count);
  end
`endif

endmodule

// File: rtl/vram_port_arbiter.sv
// Display-priority VRAM arbiter with buffered writer and stall statistic.
// Optional read-after-write forwarding from the queue: define VRAM_RAW_FWD_EN.
module vram_port_arbiter #(
  parameter int ADDR_W   = vram_pkg::DEF_ADDR_W,
  parameter int DATA_W   = vram_pkg::DEF_DATA_W,
  parameter int WQ_DEPTH = vram_pkg::DEF_WQ_DEPTH
) (
  input logic                clk,
  input logic                rst,
  vram_port_arbiter_if.slave bus
);
  import vram_pkg::*;

  localparam int CW = $clog2(WQ_DEPTH) + 1;

  state_t            state;
  state_t            next_state;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [15:0]       cur_stall;
  logic [15:0]       cur_stall_next;

`ifdef VRAM_RAW_FWD_EN
  logic [WQ_DEPTH-1:0][ADDR_W-1:0] age_addr;
  logic [WQ_DEPTH-1:0][DATA_W-1:0] age_data;
  logic [WQ_DEPTH-1:0]             age_valid;
  logic                            fwd_hit;
  logic [DATA_W-1:0]               fwd_data;
  logic                            fwd_hit_q;
  logic [DATA_W-1:0]               fwd_data_q;
`endif

  vram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.wr_addr),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
`ifdef VRAM_RAW_FWD_EN
    ,
    .age_addr  (age_addr),
    .age_data  (age_data),
    .age_valid (age_valid)
`endif
  );

  // Display always wins; the queue only drains in cycles with no fetch
  always_comb begin
    next_state = ST_IDLE;
    if (bus.disp_req)     next_state = ST_RD;
    else if (!fifo_empty) next_state = ST_WR;
  end

  assign bus.wr_ready = rst && !fifo_full;
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = rst && (next_state == ST_WR);
  assign bus.wq_count = count;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (rst) begin
      case (next_state)
        ST_RD: begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.disp_addr;
        end
        ST_WR: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = head_addr;
          bus.mem_wdata = head_data;
        end
        default: ;
      endcase
    end
  end

`ifdef VRAM_RAW_FWD_EN
  // Later (newer) matches override earlier ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (next_state == ST_RD) begin
      for (int i = 0; i < WQ_DEPTH; i++) begin
        if (age_valid[i] && (age_addr[i] == bus.disp_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = age_data[i];
        end
      end
    end
  end
`endif

  // A registered RD state means VRAM data arrives this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      bus.disp_valid <= 1'b0;
      bus.disp_data  <= '0;
`ifdef VRAM_RAW_FWD_EN
      fwd_hit_q      <= 1'b0;
      fwd_data_q     <= '0;
`endif
    end else begin
      state          <= next_state;
      bus.disp_valid <= (state == ST_RD);
`ifdef VRAM_RAW_FWD_EN
      fwd_hit_q      <= fwd_hit;
      fwd_data_q     <= fwd_data;
      if (state == ST_RD) bus.disp_data <= fwd_hit_q ? fwd_data_q : bus.mem_rdata;
`else
      if (state == ST_RD) bus.disp_data <= bus.mem_rdata;
`endif
    end
  end

  always_comb begin
    cur_stall_next = cur_stall;
    if (pop)
      cur_stall_next = '0;
    else if (!fifo_empty && (cur_stall != 16'hFFFF))
      cur_stall_next = cur_stall + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_stall        <= '0;
      bus.wr_stall_max <= '0;
    end else begin
      cur_stall        <= cur_stall_next;
      bus.wr_stall_max <= max16(bus.wr_stall_max, cur_stall_next);
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter; honours VRAM_RAW_FWD_EN for the RAW vectors.
module tb_vram_port_arbiter;
  import vram_pkg::*;

  typedef struct {
    logic [11:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    logic [18:0] addr;
    logic [11:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vram_port_arbiter_if bus ();

  vram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  rd_exp_t     rd_e;
  wr_exp_t     wr_e;
  logic [11:0] vram [int];
  logic [11:0] rd_exp;
  int          checks  = 0;
  int          passes  = 0;
  int          cyc     = 0;
  int          we_seen = 0;

  // VRAM model: unwritten words read back as their own low 12 address bits
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en && bus.mem_we)
      vram[int'(bus.mem_addr)] = bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= vram.exists(int'(bus.mem_addr)) ? vram[int'(bus.mem_addr)]
                                                        : bus.mem_addr[11:0];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.disp_valid) begin
        if (rd_q.size() == 0) begin
          check_output("rd_unexpected_valid", bus.disp_valid, 0);
        end else begin
          rd_e = rd_q.pop_front();
          check_output("rd_data", bus.disp_data, rd_e.data);
          check_output("rd_latency", cyc, rd_e.due);
        end
      end
      if (bus.mem_en && bus.mem_we) begin
        we_seen++;
        if (wr_q.size() == 0) begin
          check_output("wr_unexpected_we", bus.mem_we, 0);
        end else begin
          wr_e = wr_q.pop_front();
          check_output("wr_addr", bus.mem_addr, wr_e.addr);
          check_output("wr_data", bus.mem_wdata, wr_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    if (bus.disp_req) rd_q.push_back('{data: rd_exp, due: cyc + 2});
    step();
  endtask

  task automatic apply_stimulus(input logic req, input logic [18:0] addr, input logic [11:0] exp);
    bus.disp_req  = req;
    bus.disp_addr = addr;
    rd_exp        = exp;
  endtask

  task automatic post_write(input logic [18:0] addr, input logic [11:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    wr_q.push_back('{addr: addr, data: data});
  endtask

  task automatic idle_write();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        accepted;
    int          we_base;
    logic [11:0] f1;
    logic [11:0] f2;

    bus.disp_req  = 1'b1;
    bus.disp_addr = 19'd5;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 19'd9;
    bus.wr_data   = 12'h001;
    rd_exp        = '0;

    // Reset held with active inputs: every output must stay 0
    repeat (5) begin
      @(negedge clk);
      check_output("rst_disp_valid", bus.disp_valid, 0);
      check_output("rst_disp_data", bus.disp_data, 0);
      check_output("rst_wr_ready", bus.wr_ready, 0);
      check_output("rst_mem_en", bus.mem_en, 0);
      check_output("rst_mem_we", bus.mem_we, 0);
      check_output("rst_mem_addr", bus.mem_addr, 0);
      check_output("rst_wq_count", bus.wq_count, 0);
      check_output("rst_stall_max", bus.wr_stall_max, 0);
    end
    step();
    rst = 1'b1;
    apply_stimulus(1'b0, '0, '0);
    idle_write();
    #1;
    check_output("rel_wr_ready", bus.wr_ready, 1);
    check_output("rel_wq_count", bus.wq_count, 0);
    check_output("rel_mem_en", bus.mem_en, 0);
    step();

    $display("[TB] fetch latency over one scanline");
    for (int a = 0; a < H_ACTIVE; a++) begin
      apply_stimulus(1'b1, 19'(a), 12'(a));
      cycle();
    end
    apply_stimulus(1'b0, '0, '0);
    repeat (4) cycle();
    check_output("fetch_drained", rd_q.size(), 0);

    $display("[TB] queue fill under display and drain");
    we_base = we_seen;
    apply_stimulus(1'b1, 19'd7, 12'd7);
    for (int i = 0; i < 4; i++) begin
      post_write(19'(100 + i), 12'(12'hF00 + i));
      cycle();
    end
    post_write(19'd104, 12'hF04);
    #1;
    check_output("fill_ready_low", bus.wr_ready, 0);
    check_output("fill_count", bus.wq_count, 4);
    cycle();
    cycle();
    #1;
    check_output("fill_ready_held", bus.wr_ready, 0);
    check_output("fill_count_held", bus.wq_count, 4);
    check_output("fill_no_we", we_seen - we_base, 0);
    apply_stimulus(1'b0, '0, '0);
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      accepted = bus.wr_ready;
      cycle();
    end
    check_output("fifth_accepted", accepted, 1);
    idle_write();
    repeat (6) cycle();
    check_output("drain_count", bus.wq_count, 0);
    check_output("drain_wr_q", wr_q.size(), 0);
    check_output("drain_writes", we_seen - we_base, 5);

    $display("[TB] interleaved fetch and write");
    apply_stimulus(1'b1, 19'd11, 12'd11);
    post_write(19'd200, 12'hABC);
    cycle();
    idle_write();
    #1;
    check_output("il_held_count", bus.wq_count, 1);
    check_output("il_held_we", bus.mem_we, 0);
    cycle();
    apply_stimulus(1'b0, '0, '0);
    #1;
    check_output("il_gap_we", bus.mem_we, 1);
    check_output("il_gap_addr", bus.mem_addr, 200);
    check_output("il_gap_wdata", bus.mem_wdata, 12'hABC);
    cycle();
    apply_stimulus(1'b1, 19'd11, 12'd11);
    cycle();
    apply_stimulus(1'b0, '0, '0);
    #1;
    check_output("il_idle_en", bus.mem_en, 0);
    cycle();
    apply_stimulus(1'b1, 19'd11, 12'd11);
    cycle();
    apply_stimulus(1'b0, '0, '0);
    repeat (4) cycle();
    check_output("il_rd_q", rd_q.size(), 0);
    check_output("il_wr_q", wr_q.size(), 0);

    $display("[TB] read after queued write");
    post_write(19'd300, 12'h111);
    cycle();
    idle_write();
    repeat (3) cycle();
`ifdef VRAM_RAW_FWD_EN
    f1 = 12'h0F0;
    f2 = 12'h00F;
`else
    f1 = 12'h111;
    f2 = 12'h111;
`endif
    apply_stimulus(1'b1, 19'd20, 12'd20);
    post_write(19'd300, 12'h0F0);
    cycle();
    apply_stimulus(1'b1, 19'd300, f1);
    post_write(19'd300, 12'h00F);
    cycle();
    idle_write();
    apply_stimulus(1'b1, 19'd300, f2);
    cycle();
    apply_stimulus(1'b0, '0, '0);
    repeat (4) cycle();
    apply_stimulus(1'b1, 19'd300, 12'h00F);
    cycle();
    apply_stimulus(1'b0, '0, '0);
    repeat (4) cycle();
    check_output("raw_rd_q", rd_q.size(), 0);
    check_output("raw_wr_q", wr_q.size(), 0);

    $display("[TB] stall statistic and reset mid-read");
    apply_stimulus(1'b1, 19'd30, 12'd30);
    post_write(19'd400, 12'h555);
    cycle();
    idle_write();
    repeat (800) cycle();
    check_output("stall_max", bus.wr_stall_max, 800);
    check_output("stall_count", bus.wq_count, 1);
    rst = 1'b0;
    #1;
    rd_q.delete();
    wr_q.delete();
    we_base = we_seen;
    check_output("mid_rst_valid", bus.disp_valid, 0);
    check_output("mid_rst_count", bus.wq_count, 0);
    check_output("mid_rst_stall", bus.wr_stall_max, 0);
    check_output("mid_rst_mem_en", bus.mem_en, 0);
    step();
    check_output("mid_rst_valid_next", bus.disp_valid, 0);
    step();
    rst = 1'b1;
    apply_stimulus(1'b0, '0, '0);
    repeat (5) cycle();
    check_output("post_rst_count", bus.wq_count, 0);
    check_output("post_rst_no_we", we_seen - we_base, 0);
    check_output("post_rst_ready", bus.wr_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
